// File: rtl/sfr_update_arbiter_pkg.sv
// Shared definitions for SFR owner blocks: FSM state encoding, priority modes
// and the index-width helper used to size source indices.
package sfr_update_arbiter_pkg;

  typedef enum logic {
    SFR_ST_IDLE   = 1'b0,
    SFR_ST_LOCKED = 1'b1
  } sfr_state_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfr_rr_arbiter.sv
// Combinational request arbiter: fixed (lowest index) or round-robin search
// starting at rr_ptr; produces a one-hot grant plus its encoded index.
module sfr_rr_arbiter
  import sfr_update_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int IDXW      = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    int base;
    int cand;
    logic [IDXW-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    base     = (PRIO_MODE == PRIO_RR) ? int'(rr_ptr) : 0;
    for (int o = 0; o < NUM_SRC; o++) begin
      cand = base + o;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = IDXW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
        gnt_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfr_update_arbiter.sv
// Execute-stage owner of one status SFR: arbitrates masked read-modify-write
// sources, with stall and a bounded multi-cycle atomic lock.
module sfr_update_arbiter
  import sfr_update_arbiter_pkg::*;
#(
  parameter int                  DATA_WIDTH = 8,
  parameter int                  NUM_SRC    = 4,
  parameter int                  PRIO_MODE  = PRIO_FIXED,
  parameter int                  LOCK_MAX   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  localparam int                 IDXW       = idx_width(NUM_SRC)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_lock,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_mask,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         sfr_q,
  output logic                          upd_valid,
  output logic [IDXW-1:0]               upd_idx,
  output logic                          upd_changed
);

  localparam int CNTW = idx_width(LOCK_MAX);

  sfr_state_e             state_q, state_d;
  logic [IDXW-1:0]        owner_q, owner_d;
  logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [NUM_SRC-1:0]     req, gnt, owner_oh;
  logic [IDXW-1:0]        gnt_idx;
  logic                   gnt_any;
  logic [DATA_WIDTH-1:0]  mask_k, data_k, sfr_d;
  logic                   lock_last;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
    return (int'(v) == NUM_SRC - 1) ? '0 : v + 1'b1;
  endfunction

  // While locked only the owner may compete; stall masks every request.
  always_comb begin
    owner_oh = NUM_SRC'(1) << owner_q;
    if (stall)                       req = '0;
    else if (state_q == SFR_ST_LOCKED) req = src_valid & owner_oh;
    else                             req = src_valid;
  end

  sfr_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .PRIO_MODE (PRIO_MODE),
    .IDXW      (IDXW)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign src_ready = gnt;
  assign mask_k    = src_mask[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign data_k    = src_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sfr_d     = (sfr_q & ~mask_k) | (data_k & mask_k);
  assign lock_last = (lock_cnt_q == CNTW'(LOCK_MAX - 1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (!stall) begin
      case (state_q)
        SFR_ST_IDLE: begin
          if (gnt_any) begin
            if (PRIO_MODE == PRIO_RR) rr_ptr_d = wrap_inc(gnt_idx);
            if (src_lock[gnt_idx]) begin
              state_d    = SFR_ST_LOCKED;
              owner_d    = gnt_idx;
              lock_cnt_d = '0;
            end
          end
        end
        SFR_ST_LOCKED: begin
          // Timeout wins over the owner's request to keep the lock.
          if (lock_last || (gnt_any && !src_lock[owner_q])) begin
            state_d = SFR_ST_IDLE;
            if (PRIO_MODE == PRIO_RR) rr_ptr_d = wrap_inc(owner_q);
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        default: state_d = SFR_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SFR_ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_cnt_q  <= '0;
      sfr_q       <= RESET_VAL;
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_changed <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      upd_valid  <= gnt_any;
      if (gnt_any) begin
        sfr_q       <= sfr_d;
        upd_idx     <= gnt_idx;
        upd_changed <= (sfr_d != sfr_q);
      end
    end
  end

endmodule

// File: tb/tb_sfr_update_arbiter.sv
// Directed bench: two arbiter instances (fixed priority, RESET_VAL=A5 and
// round-robin, RESET_VAL=00) driven by one shared vector table.
module tb_sfr_update_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [3:0]  valid, lock;
  logic [31:0] mask, data;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  sfr0, sfr1;
  logic        uv0, uv1, chg0, chg1;
  logic [1:0]  idx0, idx1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic [3:0]  v, l;
    logic [31:0] m, d;
    logic [3:0]  r0, r1;
    logic [7:0]  s0, s1;
    logic        u1;
    logic [1:0]  i1;
    logic        c1;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  sfr_update_arbiter #(
    .DATA_WIDTH(8), .NUM_SRC(4), .PRIO_MODE(0), .LOCK_MAX(4), .RESET_VAL(8'hA5)
  ) dut0 (
    .clock(clk), .reset(rst), .stall(stall), .src_valid(valid), .src_lock(lock),
    .src_mask(mask), .src_data(data), .src_ready(rdy0), .sfr_q(sfr0),
    .upd_valid(uv0), .upd_idx(idx0), .upd_changed(chg0)
  );

  sfr_update_arbiter #(
    .DATA_WIDTH(8), .NUM_SRC(4), .PRIO_MODE(1), .LOCK_MAX(4), .RESET_VAL(8'h00)
  ) dut1 (
    .clock(clk), .reset(rst), .stall(stall), .src_valid(valid), .src_lock(lock),
    .src_mask(mask), .src_data(data), .src_ready(rdy1), .sfr_q(sfr1),
    .upd_valid(uv1), .upd_idx(idx1), .upd_changed(chg1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] m, input logic [31:0] d,
                     input logic [3:0] r0, input logic [3:0] r1,
                     input logic [7:0] s0, input logic [7:0] s1,
                     input logic u1, input logic [1:0] i1, input logic c1);
    vec_t x;
    x.st = st; x.v = v; x.l = l; x.m = m; x.d = d; x.r0 = r0; x.r1 = r1;
    x.s0 = s0; x.s1 = s1; x.u1 = u1; x.i1 = i1; x.c1 = c1;
    vq.push_back(x);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; valid = '0; lock = '0; mask = '0; data = '0;

    // masked writes
    add(0, 4'b0010, 4'b0000, 32'h00000F00, 32'h0000FF00, 4'b0010, 4'b0010, 8'hAF, 8'h0F, 1, 2'd1, 1);
    add(0, 4'b0010, 4'b0000, 32'h00000F00, 32'h0000FF00, 4'b0010, 4'b0010, 8'hAF, 8'h0F, 1, 2'd1, 0);
    add(0, 4'b0010, 4'b0000, 32'h00000000, 32'h0000FF00, 4'b0010, 4'b0010, 8'hAF, 8'h0F, 1, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 8'hAF, 8'h0F, 0, 2'd1, 0);
    add(0, 4'b1000, 4'b0000, 32'hFF000000, 32'h5A000000, 4'b1000, 4'b1000, 8'h5A, 8'h5A, 1, 2'd3, 1);
    // priority
    add(0, 4'b1111, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 4'b0001, 4'b0001, 8'h11, 8'h11, 1, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 4'b0001, 4'b0010, 8'h11, 8'h22, 1, 2'd1, 1);
    add(0, 4'b1111, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 4'b0001, 4'b0100, 8'h11, 8'h33, 1, 2'd2, 1);
    add(0, 4'b1111, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 4'b0001, 4'b1000, 8'h11, 8'h44, 1, 2'd3, 1);
    add(0, 4'b1001, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 4'b0001, 4'b0001, 8'h11, 8'h11, 1, 2'd0, 1);
    // lock held by src2, released by owner
    add(0, 4'b0100, 4'b0100, 32'h00FF0000, 32'h00C30000, 4'b0100, 4'b0100, 8'hC3, 8'hC3, 1, 2'd2, 1);
    add(0, 4'b0101, 4'b0100, 32'h000F00FF, 32'h000A0001, 4'b0100, 4'b0100, 8'hCA, 8'hCA, 1, 2'd2, 1);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0000, 4'b0000, 8'hCA, 8'hCA, 0, 2'd2, 1);
    add(0, 4'b0101, 4'b0000, 32'h000F00FF, 32'h000A0001, 4'b0100, 4'b0100, 8'hCA, 8'hCA, 1, 2'd2, 0);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0001, 4'b0001, 8'h01, 8'h01, 1, 2'd0, 1);
    // lock timeout without stall
    add(0, 4'b0010, 4'b0010, 32'h0000FF00, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 8'h77, 1, 2'd1, 1);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0000, 4'b0000, 8'h77, 8'h77, 0, 2'd1, 1);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0001, 4'b0001, 8'h01, 8'h01, 1, 2'd0, 1);
    // lock timeout with three stalled cycles
    add(0, 4'b0010, 4'b0010, 32'h0000FF00, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 8'h77, 1, 2'd1, 1);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0000, 4'b0000, 8'h77, 8'h77, 0, 2'd1, 1);
    for (int i = 0; i < 3; i++)
      add(1, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0000, 4'b0000, 8'h77, 8'h77, 0, 2'd1, 1);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0000, 4'b0000, 8'h77, 8'h77, 0, 2'd1, 1);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000001, 4'b0001, 4'b0001, 8'h01, 8'h01, 1, 2'd0, 1);
    // timeout while owner keeps transferring with lock=1
    add(0, 4'b0010, 4'b0010, 32'h0000FF00, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 8'h77, 1, 2'd1, 1);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0010, 4'b0010, 32'h0000FF00, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 8'h77, 1, 2'd1, 0);
    add(0, 4'b0011, 4'b0010, 32'h0000FFFF, 32'h00007701, 4'b0010, 4'b0010, 8'h77, 8'h77, 1, 2'd1, 0);
    add(0, 4'b0011, 4'b0000, 32'h0000FFFF, 32'h00007701, 4'b0001, 4'b0001, 8'h01, 8'h01, 1, 2'd0, 1);
    // stall then release
    add(1, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000080, 4'b0000, 4'b0000, 8'h01, 8'h01, 0, 2'd0, 1);
    add(0, 4'b0001, 4'b0000, 32'h000000FF, 32'h00000080, 4'b0001, 4'b0001, 8'h80, 8'h80, 1, 2'd0, 1);

    // reset values
    @(negedge clk);
    chk("rst_sfr0", 32'(sfr0), 32'hA5);
    chk("rst_sfr1", 32'(sfr1), 32'h00);
    chk("rst_uv0", 32'(uv0), 32'h0);
    chk("rst_uv1", 32'(uv1), 32'h0);
    chk("rst_idx1", 32'(idx1), 32'h0);
    chk("rst_chg1", 32'(chg1), 32'h0);
    rst = 1'b0;

    // write, then reset asserted mid-cycle
    valid = 4'b0001; mask = 32'h000000FF; data = 32'h0000003C;
    #1 chk("pre_rdy1", 32'(rdy1), 32'h1);
    @(negedge clk);
    chk("pre_sfr0", 32'(sfr0), 32'h3C);
    chk("pre_sfr1", 32'(sfr1), 32'h3C);
    valid = '0; mask = '0; data = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sfr0", 32'(sfr0), 32'hA5);
    chk("arst_sfr1", 32'(sfr1), 32'h00);
    chk("arst_uv1", 32'(uv1), 32'h0);
    chk("arst_rdy1", 32'(rdy1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_sfr0", i), 32'(sfr0), 32'hA5);
      chk($sformatf("idle%0d_sfr1", i), 32'(sfr1), 32'h00);
      chk($sformatf("idle%0d_uv1", i), 32'(uv1), 32'h0);
    end

    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].st; valid = vq[i].v; lock = vq[i].l;
      mask = vq[i].m; data = vq[i].d;
      #1;
      chk($sformatf("v%0d_rdy0", i), 32'(rdy0), 32'(vq[i].r0));
      chk($sformatf("v%0d_rdy1", i), 32'(rdy1), 32'(vq[i].r1));
      @(negedge clk);
      chk($sformatf("v%0d_sfr0", i), 32'(sfr0), 32'(vq[i].s0));
      chk($sformatf("v%0d_sfr1", i), 32'(sfr1), 32'(vq[i].s1));
      chk($sformatf("v%0d_uv1", i), 32'(uv1), 32'(vq[i].u1));
      chk($sformatf("v%0d_idx1", i), 32'(idx1), 32'(vq[i].i1));
      chk($sformatf("v%0d_chg1", i), 32'(chg1), 32'(vq[i].c1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
